score_counter: RTL and testbench
================================

Name: score_counter

Overview:
- Producer side of the score display path: accumulates the game score while a run is active and drives the binary score word consumed by the seven-segment/dot-matrix display block.
- Tracks the run state (idle / running / over), a saturating score, a session high score, and a speed level for the obstacle generator.
- Sits between the game-tick generator and collision detector on one side, and the score display block and game logic on the other.

Parameters:
- TICKS_PER_POINT, 4, number of tick_en pulses per score increment (>=1).
- SCORE_W, 10, width of score and high_score.
- SCORE_MAX, 999, saturation value of score.
- LEVEL_STEP, 100, score points per speed level.
- LEVEL_MAX, 7, saturation value of level.

Ports:
- clk2  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- tick_en  in  1  game-time pulse, one clk2 cycle wide, already synchronous to clk2.
- start  in  1  level; sampled each cycle; begins a new run.
- collide  in  1  level; sampled each cycle; ends the current run.
- score  out  SCORE_W  current score, binary, registered.
- high_score  out  SCORE_W  best score since reset, registered.
- level  out  3  speed level = min(score / LEVEL_STEP, LEVEL_MAX), registered.
- running  out  1  high while in RUN.
- game_over  out  1  high while in OVER.
- new_record  out  1  high while in OVER if the finished run beat high_score.

Behaviour:
- Interface: reset is asynchronous and active-low; clock is clk2.
- Reset (reset=0): state=IDLE; score, high_score, level=0; prescaler=0; running, game_over, new_record=0. Reset mid-run aborts immediately, with no high_score update.
- States: IDLE, RUN, OVER. running and game_over are decoded from registered state, so they are glitch-free.
- IDLE: score and level held at 0. start=1 -> RUN next edge with prescaler cleared.
- RUN, per edge, in priority order:
  - collide=1 -> OVER. No increment that cycle, even if tick_en=1.
  - tick_en=1 and prescaler==TICKS_PER_POINT-1 -> prescaler=0 and score=min(score+1, SCORE_MAX).
  - tick_en=1 otherwise -> prescaler+1.
  - start is ignored in RUN.
- RUN latency: score changes on the clk2 edge that samples the qualifying tick_en. level is computed from the next score value and updates on the same edge, so score and level are never inconsistent.
- Saturation: at score==SCORE_MAX, further ticks keep score at SCORE_MAX; the prescaler keeps cycling. level saturates at LEVEL_MAX (score >= 700 -> 7).
- Entry to OVER (RUN->OVER edge):
  - if score > high_score: high_score <= score and new_record <= 1.
  - else new_record <= 0.
  - Ties do not set new_record.
- OVER: score, level and high_score held. start=1 -> RUN next edge with score=0, level=0, prescaler=0 and new_record=0. If start and collide are both high in OVER, start wins; collide is only acted on in RUN.
- high_score is changed only by OVER entry and by reset.
- Arithmetic: all compares are unsigned SCORE_W-bit. The level divide uses a compare chain against LEVEL_STEP multiples (no divider). The prescaler is $clog2(TICKS_PER_POINT) bits, minimum 1 bit.

Decomposition:
- Shared package score_pkg holds:
  - the state enum (IDLE, RUN, OVER);
  - SCORE_W, SCORE_MAX, LEVEL_STEP and LEVEL_MAX defaults;
  - a level_of(score) function, which the display block also uses.
- One sub-module: score_prescaler.
  - Inputs: clk2, reset, clear, tick_en.
  - Output: point_pulse, high for one cycle on the terminal tick.
  - It is cleared whenever the FSM enters RUN.

Test Plan:
- Reset then start=1 for 1 cycle, 12 tick_en pulses, TICKS_PER_POINT=4 -> score=3 and running=1; each increment lands on the edge sampling the 4th, 8th and 12th tick.
- Run to score=250, then collide -> game_over=1 next edge, score=250 held, high_score=250, new_record=1, level=2.
- Second run reaches 180, then collide -> high_score stays 250, new_record=0. Restart: score=0, new_record=0.
- collide and a terminal tick_en in the same cycle at score=41 -> score stays 41, state OVER.
- Force 4000+ ticks in RUN -> score saturates at 999 and level=7; further ticks leave both unchanged.
- Assert reset=0 asynchronously mid-run at score=57 -> all outputs 0 immediately, without waiting for a clk2 edge; state IDLE; high_score=0.

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: shared types, defaults and helpers
// for the score path and the display block.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int unsigned TICKS_DEF      = 4;
    localparam int unsigned SCORE_W_DEF    = 10;
    localparam int unsigned SCORE_MAX_DEF  = 999;
    localparam int unsigned LEVEL_STEP_DEF = 100;
    localparam int unsigned LEVEL_MAX_DEF  = 7;

    // Speed level as a compare chain over step multiples, no divider.
    // A 3-bit level can never exceed 7, which bounds the chain.
    function automatic logic [2:0] level_of(
        input int unsigned s,
        input int unsigned step = LEVEL_STEP_DEF,
        input int unsigned lmax = LEVEL_MAX_DEF
    );
        logic [2:0] lv;
        lv = '0;
        for (int unsigned k = 1; k <= 7; k++) begin
            if (k <= lmax && s >= k * step) begin
                lv = 3'(k);
            end
        end
        return lv;
    endfunction

endpackage

// File: rtl/score_prescaler.sv
// score_prescaler: divides game ticks down to
// one point pulse per TICKS_PER_POINT ticks.
module score_prescaler #(
    parameter int unsigned TICKS_PER_POINT = 4
) (
    input  logic clk2,
    input  logic reset,
    input  logic clear,
    input  logic tick_en,
    output logic point_pulse
);

    localparam int unsigned PW =
        (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;

    logic [PW-1:0] r_cnt;
    logic          w_terminal;

    // Combinational so the score moves on the edge sampling the tick.
    assign w_terminal  = (r_cnt == PW'(TICKS_PER_POINT - 1));
    assign point_pulse = tick_en && w_terminal && !clear;

    // Tick counter; clear wins so every run starts on a fresh point.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (tick_en) begin
            r_cnt <= w_terminal ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/score_counter.sv
// score_counter: run-state FSM, saturating score,
// session high score and speed level.
module score_counter
    import score_pkg::*;
#(
    parameter int unsigned TICKS_PER_POINT = TICKS_DEF,
    parameter int unsigned SCORE_W         = SCORE_W_DEF,
    parameter int unsigned SCORE_MAX       = SCORE_MAX_DEF,
    parameter int unsigned LEVEL_STEP      = LEVEL_STEP_DEF,
    parameter int unsigned LEVEL_MAX       = LEVEL_MAX_DEF
) (
    input  logic               clk2,
    input  logic               reset,
    input  logic               tick_en,
    input  logic               start,
    input  logic               collide,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         level,
    output logic               running,
    output logic               game_over,
    output logic               new_record
);

    state_t             r_state;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic [2:0]         r_level;
    logic               r_new_record;

    logic               w_clear;
    logic               w_point;
    logic [SCORE_W-1:0] w_score_nxt;

    // Prescaler restarts on the edge that enters RUN.
    assign w_clear = start && (r_state != ST_RUN);

    assign w_score_nxt = (r_score == SCORE_W'(SCORE_MAX))
                       ? r_score : r_score + 1'b1;

    score_prescaler #(
        .TICKS_PER_POINT(TICKS_PER_POINT)
    ) u_presc (
        .clk2       (clk2),
        .reset      (reset),
        .clear      (w_clear),
        .tick_en    (tick_en),
        .point_pulse(w_point)
    );

    // Run FSM with score, level and high-score registers.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_score      <= '0;
            r_high       <= '0;
            r_level      <= '0;
            r_new_record <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (collide) begin
                        r_state      <= ST_OVER;
                        r_new_record <= (r_score > r_high);
                        if (r_score > r_high) begin
                            r_high <= r_score;
                        end
                    end else if (w_point) begin
                        r_score <= w_score_nxt;
                        r_level <= level_of(32'(w_score_nxt),
                                            LEVEL_STEP, LEVEL_MAX);
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_score      <= '0;
                        r_level      <= '0;
                        r_new_record <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign score      = r_score;
    assign high_score = r_high;
    assign level      = r_level;
    assign running    = (r_state == ST_RUN);
    assign game_over  = (r_state == ST_OVER);
    assign new_record = r_new_record;

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: randomized and directed run
// sequences checked against a tick-count model.
module tb_score_counter;

    localparam int TPP = 4;
    localparam int SMAX = 999;

    typedef struct packed {
        logic [9:0] sc;
        logic [9:0] hi;
        logic [2:0] lv;
        logic       run;
        logic       ov;
        logic       rec;
    } obs_t;

    logic       clk2 = 1'b0;
    logic       reset = 1'b0;
    logic       tick_en = 1'b0;
    logic       start = 1'b0;
    logic       collide = 1'b0;
    logic [9:0] score;
    logic [9:0] high_score;
    logic [2:0] level;
    logic       running;
    logic       game_over;
    logic       new_record;

    int n_vec = 0;
    int n_bad = 0;
    obs_t q[$];

    // Reference: a run is just a count of ticks seen while running.
    bit m_run = 0;
    bit m_over = 0;
    bit m_rec = 0;
    int m_ticks = 0;
    int m_high = 0;

    score_counter dut (
        .clk2      (clk2),
        .reset     (reset),
        .tick_en   (tick_en),
        .start     (start),
        .collide   (collide),
        .score     (score),
        .high_score(high_score),
        .level     (level),
        .running   (running),
        .game_over (game_over),
        .new_record(new_record)
    );

    always #5 clk2 = ~clk2;

    function automatic int m_score();
        int s;
        if (!m_run && !m_over) return 0;
        s = m_ticks / TPP;
        return (s > SMAX) ? SMAX : s;
    endfunction

    function automatic obs_t m_expect();
        obs_t e;
        int s;
        int l;
        s = m_score();
        l = s / 100;
        if (l > 7) l = 7;
        e.sc  = 10'(s);
        e.hi  = 10'(m_high);
        e.lv  = 3'(l);
        e.run = m_run;
        e.ov  = m_over;
        e.rec = m_rec;
        return e;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.sc  = score;
        o.hi  = high_score;
        o.lv  = level;
        o.run = running;
        o.ov  = game_over;
        o.rec = new_record;
        return o;
    endfunction

    task automatic check(input string nm, input obs_t a, input obs_t e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got sc=%0d hi=%0d lv=%0d run=%b ov=%b rec=%b want sc=%0d hi=%0d lv=%0d run=%b ov=%b rec=%b",
                     nm, a.sc, a.hi, a.lv, a.run, a.ov, a.rec,
                     e.sc, e.hi, e.lv, e.run, e.ov, e.rec);
        end
    endtask

    task automatic m_edge(input bit s, input bit c, input bit t);
        if (m_run) begin
            if (c) begin
                m_run  = 0;
                m_over = 1;
                m_rec  = (m_score() > m_high);
                if (m_rec) m_high = m_score();
            end else if (t) begin
                m_ticks++;
            end
        end else if (s) begin
            m_run   = 1;
            m_over  = 0;
            m_ticks = 0;
            m_rec   = 0;
        end
    endtask

    task automatic step(input bit s, input bit c, input bit t);
        @(negedge clk2);
        start   = s;
        collide = c;
        tick_en = t;
        @(posedge clk2);
        m_edge(s, c, t);
        q.push_back(m_expect());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1);
    endtask

    // Monitor: every edge yields one registered output vector.
    initial begin
        forever begin
            @(posedge clk2);
            #1;
            if (q.size() > 0) check("cycle", dut_obs(), q.pop_front());
        end
    end

    initial begin
        obs_t z;
        z = '0;
        #12;
        check("reset_state", dut_obs(), z);
        @(negedge clk2);
        reset = 1'b1;

        step(1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        ticks(988);
        step(0, 1, 0);
        step(0, 0, 0);

        step(1, 0, 0);
        ticks(720);
        step(0, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        ticks(167);
        step(0, 1, 1);
        step(0, 0, 1);
        step(1, 1, 0);

        ticks(4100);
        ticks(50);
        step(0, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 20) == 0,
                 ($urandom % 25) == 0,
                 ($urandom % 3) == 0);
        end

        if (m_run) step(0, 1, 0);
        step(1, 0, 0);
        ticks(228);
        step(0, 0, 0);
        @(negedge clk2);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", dut_obs(), z);
        m_run = 0; m_over = 0; m_rec = 0;
        m_ticks = 0; m_high = 0;
        @(negedge clk2);
        reset = 1'b1;
        step(0, 0, 0);
        step(1, 0, 0);
        ticks(8);
        step(0, 1, 0);
        step(0, 0, 0);

        repeat (3) @(posedge clk2);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
